// File: rtl/steer_pkg.sv
// rtl/steer_pkg.sv - shared types and default constants for the rider load evaluation stage
package steer_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    READY = 1'b1
  } prime_state_t;

  localparam int LD_W  = 12;
  localparam int SUM_W = 13;

  localparam logic [SUM_W-1:0] MIN_RIDER_WT_DEF  = 13'h0200;
  localparam logic [SUM_W-1:0] WT_HYSTERESIS_DEF = 13'h0040;
  localparam logic [25:0]      TMR_FULL_CNT_DEF  = 26'd65_000_000;

endpackage

// File: rtl/steer_tmr.sv
// rtl/steer_tmr.sv - saturating rider-settle counter with clear priority
module steer_tmr #(
  parameter logic [25:0] TMR_FULL_CNT = 26'd65_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_tmr,
  output logic tmr_full
);

  logic [25:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_tmr) begin
      cnt <= '0;
    end else if (cnt != TMR_FULL_CNT) begin
      cnt <= cnt + 26'd1;
    end
  end

  assign tmr_full = (cnt == TMR_FULL_CNT);

endmodule

// File: rtl/rider_load_eval.sv
// rtl/rider_load_eval.sv - two-stage load-cell threshold pipeline, priming FSM and settle timer
// Optional 4-deep moving-average input filter enabled by LOAD_FILTER_EN.
module rider_load_eval
  import steer_pkg::*;
#(
  parameter logic [SUM_W-1:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [SUM_W-1:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF,
  parameter logic [25:0]      TMR_FULL_CNT  = TMR_FULL_CNT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  input  logic            clr_tmr,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16,
  output logic            tmr_full
);

  localparam logic [SUM_W-1:0] GT_THR = MIN_RIDER_WT + WT_HYSTERESIS;
  localparam logic [SUM_W-1:0] LT_THR = MIN_RIDER_WT - WT_HYSTERESIS;

  prime_state_t    state;
  logic [LD_W-1:0] lft_in, rght_in;
  logic            take;
  logic [LD_W-1:0] lft_q, rght_q;
  logic            vld_q;

`ifdef LOAD_FILTER_EN
  logic [LD_W-1:0] lft_h0, lft_h1, lft_h2;
  logic [LD_W-1:0] rght_h0, rght_h1, rght_h2;
  logic [1:0]      fill_cnt;
  logic [13:0]     lft_acc, rght_acc;

  assign lft_acc  = 14'(lft_ld) + 14'(lft_h0) + 14'(lft_h1) + 14'(lft_h2);
  assign rght_acc = 14'(rght_ld) + 14'(rght_h0) + 14'(rght_h1) + 14'(rght_h2);
  assign lft_in   = lft_acc[13:2];
  assign rght_in  = rght_acc[13:2];
  // The fourth strobe after reset is the first one with a full window.
  assign take     = (state == READY) || (fill_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_h0   <= '0;
      lft_h1   <= '0;
      lft_h2   <= '0;
      rght_h0  <= '0;
      rght_h1  <= '0;
      rght_h2  <= '0;
      fill_cnt <= '0;
    end else if (ld_vld) begin
      lft_h0  <= lft_ld;
      lft_h1  <= lft_h0;
      lft_h2  <= lft_h1;
      rght_h0 <= rght_ld;
      rght_h1 <= rght_h0;
      rght_h2 <= rght_h1;
      if (state == PRIME && fill_cnt != 2'd3) begin
        fill_cnt <= fill_cnt + 2'd1;
      end
    end
  end
`else
  assign lft_in  = lft_ld;
  assign rght_in = rght_ld;
  assign take    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= ld_vld && take;
      if (ld_vld) begin
        lft_q  <= lft_in;
        rght_q <= rght_in;
      end
    end
  end

  logic [SUM_W-1:0] sum, quarter, fifteen_16, diff_ext;
  logic [LD_W-1:0]  diff;

  assign sum        = SUM_W'(lft_q) + SUM_W'(rght_q);
  assign diff       = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
  assign diff_ext   = SUM_W'(diff);
  assign quarter    = sum >> 2;
  assign fifteen_16 = sum - (sum >> 4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= PRIME;
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_1_4   <= 1'b0;
      diff_gt_15_16 <= 1'b0;
    end else if (vld_q) begin
      sum_gt_min    <= (sum > GT_THR);
      sum_lt_min    <= (sum < LT_THR);
      diff_gt_1_4   <= (diff_ext > quarter);
      diff_gt_15_16 <= (diff_ext > fifteen_16);
      if (state == PRIME) begin
        state <= READY;
      end
    end
  end

  steer_tmr #(
    .TMR_FULL_CNT(TMR_FULL_CNT)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_tmr  (clr_tmr),
    .tmr_full (tmr_full)
  );

endmodule

// File: tb/tb_rider_load_eval.sv
// tb/tb_rider_load_eval.sv - directed self-checking bench for rider_load_eval (LOAD_FILTER_EN aware)
module tb_rider_load_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        ld_vld = 1'b0;
  logic        clr_tmr = 1'b0;
  logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rider_load_eval #(
    .TMR_FULL_CNT(26'd20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .ld_vld        (ld_vld),
    .clr_tmr       (clr_tmr),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16),
    .tmr_full      (tmr_full)
  );

  // Flags packed as {gt, lt, diff_1_4, diff_15_16}.
  wire [3:0] flags = {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ld_vld = 1'b0; clr_tmr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one strobe for one cycle, then return two negedges later with flags settled.
  task automatic strobe(input logic [11:0] l, input logic [11:0] r);
    @(negedge clk);
    lft_ld = l; rght_ld = r; ld_vld = 1'b1;
    @(negedge clk);
    ld_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({flags, tmr_full} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_values actual=%b required=%b", {flags, tmr_full}, 5'b01000);
    end
`ifndef LOAD_FILTER_EN
    @(negedge clk);
    lft_ld = 12'd300; rght_ld = 12'd300; ld_vld = 1'b1;
    @(negedge clk);
    ld_vld = 1'b0;
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("FAIL latency_not_early actual=%b required=%b", flags, 4'b0100);
    end
    @(negedge clk);
    checks++;
    if (flags !== 4'b1000) begin
      failures++;
      $display("FAIL first_strobe_300_300 actual=%b required=%b", flags, 4'b1000);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (flags !== 4'b1000) begin
      failures++;
      $display("FAIL flag_hold actual=%b required=%b", flags, 4'b1000);
    end
`endif
  endtask

  task automatic test_hysteresis();
    strobe(12'd200, 12'd200);
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("FAIL hyst_sum400 actual=%b required=%b", flags, 4'b0100);
    end
    strobe(12'd250, 12'd250);
    checks++;
    if (flags !== 4'b0000) begin
      failures++;
      $display("FAIL hyst_sum500 actual=%b required=%b", flags, 4'b0000);
    end
    strobe(12'd289, 12'd288);
    checks++;
    if (flags !== 4'b1000) begin
      failures++;
      $display("FAIL hyst_sum577 actual=%b required=%b", flags, 4'b1000);
    end
    strobe(12'd288, 12'd288);
    checks++;
    if (flags !== 4'b0000) begin
      failures++;
      $display("FAIL hyst_sum576 actual=%b required=%b", flags, 4'b0000);
    end
    strobe(12'd224, 12'd224);
    checks++;
    if (flags !== 4'b0000) begin
      failures++;
      $display("FAIL hyst_sum448 actual=%b required=%b", flags, 4'b0000);
    end
  endtask

  task automatic test_diff();
    strobe(12'd400, 12'd200);
    checks++;
    if (flags !== 4'b1010) begin
      failures++;
      $display("FAIL diff_400_200 actual=%b required=%b", flags, 4'b1010);
    end
    strobe(12'd590, 12'd10);
    checks++;
    if (flags !== 4'b1011) begin
      failures++;
      $display("FAIL diff_590_10 actual=%b required=%b", flags, 4'b1011);
    end
    strobe(12'd375, 12'd225);
    checks++;
    if (flags !== 4'b1000) begin
      failures++;
      $display("FAIL diff_375_225 actual=%b required=%b", flags, 4'b1000);
    end
    strobe(12'd19, 12'd581);
    checks++;
    if (flags !== 4'b1010) begin
      failures++;
      $display("FAIL diff_19_581 actual=%b required=%b", flags, 4'b1010);
    end
  endtask

  task automatic test_timer();
    @(negedge clk);
    clr_tmr = 1'b1;
    @(negedge clk);
    clr_tmr = 1'b0;
    checks++;
    if (tmr_full !== 1'b0) begin
      failures++;
      $display("FAIL tmr_after_clear actual=%b required=%b", tmr_full, 1'b0);
    end
    repeat (19) @(negedge clk);
    checks++;
    if (tmr_full !== 1'b0) begin
      failures++;
      $display("FAIL tmr_cnt19 actual=%b required=%b", tmr_full, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (tmr_full !== 1'b1) begin
      failures++;
      $display("FAIL tmr_cnt20 actual=%b required=%b", tmr_full, 1'b1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tmr_full !== 1'b1) begin
      failures++;
      $display("FAIL tmr_hold actual=%b required=%b", tmr_full, 1'b1);
    end
    clr_tmr = 1'b1;
    @(negedge clk);
    clr_tmr = 1'b0;
    checks++;
    if (tmr_full !== 1'b0) begin
      failures++;
      $display("FAIL tmr_clear_at_full actual=%b required=%b", tmr_full, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    lft_ld = 12'd300; rght_ld = 12'd300; ld_vld = 1'b1; clr_tmr = 1'b1;
    @(negedge clk);
    lft_ld = 12'd100; rght_ld = 12'd100; clr_tmr = 1'b0;
    @(negedge clk);
    ld_vld = 1'b0;
    checks++;
    if (flags !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_first actual=%b required=%b", flags, 4'b1000);
    end
    checks++;
    if (tmr_full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clr_with_strobe actual=%b required=%b", tmr_full, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_second actual=%b required=%b", flags, 4'b0100);
    end
  endtask

  task automatic test_reset_mid_pipe();
    strobe(12'd300, 12'd300);
    @(negedge clk);
    lft_ld = 12'd590; rght_ld = 12'd10; ld_vld = 1'b1;
    @(negedge clk);
    ld_vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("FAIL rst_mid_pipe actual=%b required=%b", flags, 4'b0100);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("FAIL rst_mid_pipe_later actual=%b required=%b", flags, 4'b0100);
    end
  endtask

  task automatic test_filter();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(12'd600, 12'd0);
      checks++;
      if (flags !== 4'b0100) begin
        failures++;
        $display("FAIL filter_prime_%0d actual=%b required=%b", i + 1, flags, 4'b0100);
      end
    end
    strobe(12'd600, 12'd0);
    checks++;
    if (flags !== 4'b1011) begin
      failures++;
      $display("FAIL filter_fourth actual=%b required=%b", flags, 4'b1011);
    end
    // Window now holds 600,600,600,100 -> avg 475 vs 0: sum 475 in band, diff 475 > 118 and > 446.
    strobe(12'd100, 12'd0);
    checks++;
    if (flags !== 4'b0011) begin
      failures++;
      $display("FAIL filter_avg actual=%b required=%b", flags, 4'b0011);
    end
  endtask

  initial begin
    test_reset();
`ifndef LOAD_FILTER_EN
    test_hysteresis();
    test_diff();
`endif
    test_timer();
`ifndef LOAD_FILTER_EN
    test_back_to_back();
    test_reset_mid_pipe();
`else
    test_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rider_load_eval.md
# rider_load_eval

Load-cell evaluation and timing stage that sits directly upstream of the steering-enable state machine. Takes left and right load-cell readings from the A2D interface on a valid strobe and registers the sum and difference threshold flags that the state machine consumes. Also owns the 1.3 s rider-settle timer, which the state machine clears and polls.

## Interface

Parameters:
- MIN_RIDER_WT, 13'h0200: minimum rider weight, in summed load-cell counts.
- WT_HYSTERESIS, 13'h0040: hysteresis band applied on each side of MIN_RIDER_WT.
- TMR_FULL_CNT, 26'd65_000_000: settle time in clocks (1.3 s at 50 MHz).

Ports:
- clk  in  1  50 MHz clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- lft_ld  in  12  left load-cell reading, unsigned.
- rght_ld  in  12  right load-cell reading, unsigned.
- ld_vld  in  1  one-cycle strobe; lft_ld and rght_ld are valid in that cycle.
- clr_tmr  in  1  clears the settle timer.
- sum_gt_min  out  1  sum > MIN_RIDER_WT + WT_HYSTERESIS.
- sum_lt_min  out  1  sum < MIN_RIDER_WT − WT_HYSTERESIS.
- diff_gt_1_4  out  1  |lft − rght| > sum/4.
- diff_gt_15_16  out  1  |lft − rght| > sum − sum/16.
- tmr_full  out  1  settle timer has reached TMR_FULL_CNT.

## Operation

- **Reset values:** sum_gt_min=0, sum_lt_min=1 (no rider), diff_gt_1_4=0, diff_gt_15_16=0, tmr_full=0. Reset also clears the timer, all pipeline and filter registers, and the priming state.
- **Pipeline stage 1:** on ld_vld, capture lft_ld and rght_ld (raw, or the filtered values; see Configuration) into lft_q and rght_q.
- **Pipeline stage 2:**
  - sum = lft_q + rght_q, 13 bits, with no overflow possible.
  - diff = |lft_q − rght_q|, 12 bits.
  - Thresholds are sum>>2 and sum − (sum>>4), both computed in 13 bits with truncating shifts.
  - All comparisons are unsigned and strict.
  - The four flags are registered together in this stage.
- **Flag hold:** flags update only as a result of a strobe and hold their value between strobes.
- **Priming state machine:** states PRIME and READY.
  - Reset enters PRIME.
  - Flags keep their reset values until the first flag update, after which the state is READY.
  - READY is left only by reset.
- **Settle timer:** 26-bit counter.
  - clr_tmr=1: the counter becomes 0 on the next clock. Clear has priority over count.
  - Otherwise the counter increments and saturates at TMR_FULL_CNT.
  - tmr_full = (cnt == TMR_FULL_CNT), decoded combinationally from the counter register.
  - tmr_full stays asserted until the next clr_tmr.
  - The timer runs independently of ld_vld.
- **Simultaneous events:**
  - ld_vld together with clr_tmr: both take effect.
  - ld_vld on back-to-back cycles: each strobe is processed in order, with no drop.
  - rst_n low takes priority over everything at the next edge, including mid-pipeline. In-flight samples are discarded.

## Timing

- Flag latency: a strobe at cycle N produces flags visible after the edge ending cycle N+1 (2 registers).
- Timer: after clr_tmr is asserted in cycle N, cnt=0 in N+1, and tmr_full first asserts TMR_FULL_CNT cycles after that.
- Throughput: one sample per clock.

## Configuration

- **LOAD_FILTER_EN defined:**
  - Each cell passes through a 4-deep moving average: sum of the last 4 samples, using a 14-bit accumulator, then >>2.
  - PRIME requires 4 strobes. Strobes 1–3 fill the filter and do not update the flags; strobe 4 is the first flag update.
  - A 2-bit fill counter is used in PRIME.
- **Undefined:**
  - Raw samples are registered directly.
  - The first strobe updates the flags and moves the state to READY.
  - No filter registers exist.

## Structure

- **Package steer_pkg:**
  - the PRIME/READY state enum typedef;
  - LD_W=12 and SUM_W=13 localparams;
  - default MIN_RIDER_WT, WT_HYSTERESIS and TMR_FULL_CNT constants.
- **Sub-module steer_tmr:** the settle counter with clear priority and saturation, producing tmr_full.
- The comparison pipeline, filter and priming state machine stay in rider_load_eval.

## Test plan

Default thresholds apply unless stated: gt when sum > 576, lt when sum < 448. Filter is off unless stated.

- **Reset:** reset, no strobes → sum_lt_min=1 and all other outputs 0. Strobe lft=300, rght=300 → 2 cycles later sum_gt_min=1, sum_lt_min=0, diff flags 0.
- **Hysteresis band:** strobe 200/200 (sum 400) → lt=1, gt=0. Then 250/250 (sum 500) → lt=0, gt=0. Then 289/288 (sum 577) → gt=1.
- **Difference thresholds:**
  - 400/200 (sum 600, diff 200 > 150) → diff_gt_1_4=1, diff_gt_15_16=0.
  - 590/10 (diff 580 > 563) → both 1.
  - 375/225 (diff 150) → diff_gt_1_4=0 (strict compare).
- **Timer (TMR_FULL_CNT overridden to 20):**
  - clr_tmr pulse → tmr_full asserts 20 cycles after cnt=0 and holds.
  - clr_tmr asserted in the same cycle as full → cnt=0 and tmr_full=0 next cycle.
- **Back-to-back and reset mid-pipeline:**
  - Strobes 300/300 then 100/100 on consecutive cycles → gt=1 then lt=1 on consecutive cycles.
  - rst_n low the cycle after a strobe → that sample is never reflected in the flags.
- **LOAD_FILTER_EN:** four strobes of 600/0 → flags frozen at reset values until the 4th strobe, then gt=1 and both diff flags 1.
